shift_align_lock: RTL and testbench

- Parametrised successor to the fixed 16-lane aligner. Takes NUM_CH bit-shifted candidate copies of one deserialised stream and counts sync words on each lane. It locks onto the first lane to reach LOCK_LEVEL and forwards that lane's words.
- New behaviour: loss-of-lock detection with hysteresis, explicit relock request, lane-index/status outputs and a deterministic tie-break.
- Sits between the gearbox/bit-slip bank and the frame decoder in the RX path.

---
 rtl/shift_align_pkg.sv | 16 +
 rtl/sync_lane_counter.sv | 37 +++
 rtl/shift_align_lock.sv | 186 ++++++++++++++++++
 tb/tb_shift_align_lock.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_align_pkg.sv
// Shared types and helpers for the shift_align_lock lane aligner.
package shift_align_pkg;

    localparam logic [15:0] SYNC_PATTERN_DEFAULT = 16'b1000_0001_0111_1110;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } align_state_t;

    // LSB position of lane 'lane' inside a flat bus of 'width'-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/sync_lane_counter.sv
// Per-lane sync word counter: flags a sync hit and the cycle the count would reach LOCK_LEVEL.
module sync_lane_counter
    import shift_align_pkg::*;
#(
    parameter int                DATA_W       = 16,
    parameter logic [DATA_W-1:0] SYNC_PATTERN = DATA_W'(SYNC_PATTERN_DEFAULT),
    parameter int                LOCK_LEVEL   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid,
    input  logic [DATA_W-1:0] word,
    input  logic              clear,
    input  logic              enable,
    output logic              hit,
    output logic              reached
);

    localparam int CNT_W = $clog2(LOCK_LEVEL + 1);

    logic [CNT_W-1:0] count;

    assign hit     = valid && (word == SYNC_PATTERN);
    // Asserted on the sync word that completes the count, so the lock can be taken this cycle.
    assign reached = enable && hit && (count == CNT_W'(LOCK_LEVEL - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && hit) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shift_align_lock.sv
// Lane aligner: locks onto the first candidate lane to collect LOCK_LEVEL sync words and forwards it.
// Optional lock-loss statistics counter enabled by defining SHIFT_ALIGN_STATS_EN.
module shift_align_lock
    import shift_align_pkg::*;
#(
    parameter int                NUM_CH       = 16,
    parameter int                DATA_W       = 16,
    parameter logic [DATA_W-1:0] SYNC_PATTERN = DATA_W'(SYNC_PATTERN_DEFAULT),
    parameter int                LOCK_LEVEL   = 16,
    parameter int                SYNC_TIMEOUT = 64,
    parameter int                UNLOCK_LEVEL = 8,
    parameter int                IDX_W        = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        valid_in,
    input  logic [NUM_CH*DATA_W-1:0] datain,
    input  logic                     relock_req,
    output logic                     valid_o,
    output logic [DATA_W-1:0]        dataout,
    output logic                     locked,
    output logic [IDX_W-1:0]         lock_idx,
    output logic                     lock_lost,
    output logic [15:0]              relock_count
);

    localparam int GAP_W  = $clog2(SYNC_TIMEOUT + 1);
    localparam int MISS_W = $clog2(UNLOCK_LEVEL + 1);

    align_state_t      state, state_nx;
    logic [IDX_W-1:0]  idx_nx, win_idx;
    logic [GAP_W-1:0]  gap_cnt, gap_nx;
    logic [MISS_W-1:0] miss_cnt, miss_nx;
    logic              lock_ev, unlock_ev, clear_all, search_en;
    logic              lane_hit, lane_vld;

    logic [NUM_CH-1:0] vld_p1;
    logic [DATA_W-1:0] data_p1 [NUM_CH];
    logic              vld_p2;
    logic [DATA_W-1:0] dout_p2;

    logic [NUM_CH-1:0] hit, reached;

    // Stage 1: register all candidate lanes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= '0;
            for (int i = 0; i < NUM_CH; i++) data_p1[i] <= '0;
        end else begin
            vld_p1 <= valid_in;
            for (int i = 0; i < NUM_CH; i++) data_p1[i] <= datain[lane_lsb(i, DATA_W) +: DATA_W];
        end
    end

    assign search_en = (state == SEARCH);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        sync_lane_counter #(
            .DATA_W      (DATA_W),
            .SYNC_PATTERN(SYNC_PATTERN),
            .LOCK_LEVEL  (LOCK_LEVEL)
        ) u_cnt (
            .clk    (clk),
            .reset_n(reset_n),
            .valid  (vld_p1[g]),
            .word   (data_p1[g]),
            .clear  (clear_all),
            .enable (search_en),
            .hit    (hit[g]),
            .reached(reached[g])
        );
    end

    // Descending scan so the lowest reaching lane is the last assignment and wins ties.
    always_comb begin
        lock_ev = 1'b0;
        win_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (reached[i]) begin
                lock_ev = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end

    assign lane_hit = hit[lock_idx];
    assign lane_vld = vld_p1[lock_idx];

    always_comb begin
        state_nx  = state;
        idx_nx    = lock_idx;
        gap_nx    = gap_cnt;
        miss_nx   = miss_cnt;
        unlock_ev = 1'b0;
        clear_all = 1'b0;
        case (state)
            SEARCH: begin
                if (lock_ev) begin
                    state_nx  = LOCKED;
                    idx_nx    = win_idx;
                    clear_all = 1'b1;
                    gap_nx    = '0;
                    miss_nx   = '0;
                end
            end
            LOCKED: begin
                if (lane_hit) begin
                    gap_nx  = '0;
                    miss_nx = '0;
                end else if (lane_vld) begin
                    if (gap_cnt == GAP_W'(SYNC_TIMEOUT - 1)) begin
                        gap_nx = '0;
                        if (miss_cnt == MISS_W'(UNLOCK_LEVEL - 1)) begin
                            unlock_ev = 1'b1;
                            state_nx  = SEARCH;
                            clear_all = 1'b1;
                            miss_nx   = '0;
                        end else begin
                            miss_nx = miss_cnt + MISS_W'(1);
                        end
                    end else begin
                        gap_nx = gap_cnt + GAP_W'(1);
                    end
                end
            end
            default: state_nx = SEARCH;
        endcase
        // A relock request overrides both a fresh lock and a miss-driven unlock.
        if (relock_req) begin
            state_nx  = SEARCH;
            idx_nx    = lock_idx;
            clear_all = 1'b1;
            gap_nx    = '0;
            miss_nx   = '0;
            unlock_ev = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SEARCH;
            lock_idx  <= '0;
            gap_cnt   <= '0;
            miss_cnt  <= '0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_nx;
            lock_idx  <= idx_nx;
            gap_cnt   <= gap_nx;
            miss_cnt  <= miss_nx;
            lock_lost <= unlock_ev;
        end
    end

    // Stage 2: selected lane, valid only once the lock was already in place
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2  <= 1'b0;
            dout_p2 <= '0;
        end else begin
            vld_p2  <= vld_p1[lock_idx] && (state == LOCKED);
            dout_p2 <= data_p1[lock_idx];
        end
    end

    assign locked  = (state == LOCKED);
    assign valid_o = vld_p2 && locked;
    assign dataout = dout_p2;

`ifdef SHIFT_ALIGN_STATS_EN
    logic [15:0] relock_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            relock_cnt <= '0;
        end else if (unlock_ev && (relock_cnt != 16'hFFFF)) begin
            relock_cnt <= relock_cnt + 16'd1;
        end
    end

    assign relock_count = relock_cnt;
`else
    assign relock_count = 16'h0000;
`endif

endmodule

// File: tb/tb_shift_align_lock.sv
// Randomised bench for shift_align_lock with a word-level behavioural model and per-cycle comparison.
module tb_shift_align_lock;

    localparam int NUM_CH       = 16;
    localparam int DATA_W       = 16;
    localparam int LOCK_LEVEL   = 16;
    localparam int SYNC_TIMEOUT = 64;
    localparam int UNLOCK_LEVEL = 8;
    localparam int IDX_W        = 4;
    localparam logic [DATA_W-1:0] SYNC = 16'b1000_0001_0111_1110;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b1;
    logic [NUM_CH-1:0]        valid_in = '0;
    logic [NUM_CH*DATA_W-1:0] datain = '0;
    logic                     relock_req = 1'b0;
    logic                     valid_o;
    logic [DATA_W-1:0]        dataout;
    logic                     locked;
    logic [IDX_W-1:0]         lock_idx;
    logic                     lock_lost;
    logic [15:0]              relock_count;

    shift_align_lock #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .SYNC_PATTERN(SYNC),
        .LOCK_LEVEL  (LOCK_LEVEL),
        .SYNC_TIMEOUT(SYNC_TIMEOUT),
        .UNLOCK_LEVEL(UNLOCK_LEVEL),
        .IDX_W       (IDX_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .valid_in    (valid_in),
        .datain      (datain),
        .relock_req  (relock_req),
        .valid_o     (valid_o),
        .dataout     (dataout),
        .locked      (locked),
        .lock_idx    (lock_idx),
        .lock_lost   (lock_lost),
        .relock_count(relock_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_lost = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int                cnt [NUM_CH];
    bit                m_locked;
    int                m_idx;
    int                gap, miss;
    bit                m_lost;
    int                rcount;
    bit                h_v [NUM_CH];
    logic [DATA_W-1:0] h_d [NUM_CH];
    bit                exp_valid;
    logic [DATA_W-1:0] exp_dout;

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            cnt[i] = 0;
            h_v[i] = 1'b0;
            h_d[i] = '0;
        end
        m_locked  = 1'b0;
        m_idx     = 0;
        gap       = 0;
        miss      = 0;
        m_lost    = 1'b0;
        rcount    = 0;
        exp_valid = 1'b0;
        exp_dout  = '0;
    endtask

    // h_v/h_d hold the words registered one edge ago; they are the words judged at this edge.
    task automatic model_edge();
        bit was_locked;
        int old_idx;
        int win;
        was_locked = m_locked;
        old_idx    = m_idx;
        m_lost     = 1'b0;
        if (relock_req) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
            gap      = 0;
            miss     = 0;
            m_locked = 1'b0;
        end else if (!m_locked) begin
            win = -1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (h_v[i] && h_d[i] == SYNC) cnt[i]++;
                if (cnt[i] == LOCK_LEVEL && win < 0) win = i;
            end
            if (win >= 0) begin
                m_locked = 1'b1;
                m_idx    = win;
                for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
            end
        end else begin
            if (h_v[m_idx] && h_d[m_idx] == SYNC) begin
                gap  = 0;
                miss = 0;
            end else if (h_v[m_idx]) begin
                gap++;
                if (gap == SYNC_TIMEOUT) begin
                    gap = 0;
                    miss++;
                end
                if (miss == UNLOCK_LEVEL) begin
                    m_locked = 1'b0;
                    m_lost   = 1'b1;
                    miss     = 0;
                    if (rcount < 65535) rcount++;
                end
            end
        end
        exp_valid = was_locked && m_locked && h_v[old_idx];
        exp_dout  = h_d[old_idx];
        for (int i = 0; i < NUM_CH; i++) begin
            h_v[i] = valid_in[i];
            h_d[i] = datain[i*DATA_W +: DATA_W];
        end
    endtask

    initial model_reset();

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_edge();
    end

    always @(negedge clk) begin
        check("locked", locked, m_locked);
        check("lock_idx", lock_idx, m_idx);
        check("lock_lost", lock_lost, m_lost);
        check("valid_o", valid_o, exp_valid);
        if (exp_valid) check("dataout", dataout, exp_dout);
`ifdef SHIFT_ALIGN_STATS_EN
        check("relock_count", relock_count, rcount);
`else
        check("relock_count", relock_count, 0);
`endif
        if (lock_lost) n_lost++;
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        w = DATA_W'($urandom);
        if (w == SYNC) w = ~w;
        return w;
    endfunction

    task automatic set_lane(input int i, input bit v, input logic [DATA_W-1:0] w);
        valid_in[i]                = v;
        datain[i*DATA_W +: DATA_W] = w;
    endtask

    task automatic fill_random(input int vld_pct);
        for (int i = 0; i < NUM_CH; i++) set_lane(i, ($urandom_range(0, 99) < vld_pct), rand_word());
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush(input int n);
        valid_in = '0;
        repeat (n) step();
    endtask

    task automatic relock();
        valid_in   = '0;
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
    endtask

    task automatic send_syncs(input int lane, input int n, input bit gaps);
        int sent;
        int r;
        sent = 0;
        while (sent < n) begin
            fill_random(50);
            r = gaps ? $urandom_range(0, 2) : 0;
            case (r)
                0: begin set_lane(lane, 1'b1, SYNC); sent++; end
                1: set_lane(lane, 1'b1, rand_word());
                default: set_lane(lane, 1'b0, SYNC);
            endcase
            step();
        end
    endtask

    task automatic nonsync(input int lane, input int n);
        repeat (n) begin
            fill_random(50);
            set_lane(lane, 1'b1, rand_word());
            step();
        end
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int base;
        int first_valid;
        int exp_rc;

        #1 reset_n = 1'b0;
        #20;
        check("reset_locked", locked, 0);
        check("reset_valid_o", valid_o, 0);
        check("reset_lock_lost", lock_lost, 0);
        check("reset_lock_idx", lock_idx, 0);
        check("reset_dataout", dataout, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Lane 5 reaches 16 syncs amid random traffic
        send_syncs(5, 16, 1'b1);
        flush(3);
        check("lane5_locked", locked, 1);
        check("lane5_idx", lock_idx, 5);

        // Lanes 3 and 9 complete on the same cycle: lower index wins
        relock();
        repeat (16) begin
            fill_random(50);
            set_lane(3, 1'b1, SYNC);
            set_lane(9, 1'b1, SYNC);
            step();
        end
        flush(3);
        check("tie_locked", locked, 1);
        check("tie_idx", lock_idx, 3);

        // 8 x 64 non-sync words drop the lock exactly once
        relock();
        send_syncs(5, 16, 1'b0);
        base = n_lost;
        nonsync(5, UNLOCK_LEVEL * SYNC_TIMEOUT);
        flush(3);
        check("miss_lost_pulses", n_lost - base, 1);
        check("miss_unlocked", locked, 0);
        check("miss_valid_o", valid_o, 0);
`ifdef SHIFT_ALIGN_STATS_EN
        exp_rc = 1;
`else
        exp_rc = 0;
`endif
        check("miss_relock_count", relock_count, exp_rc);

        // Seven timeouts then a sync keep the lock; the next 8 timeouts drop it
        send_syncs(5, 16, 1'b0);
        base = n_lost;
        nonsync(5, 7 * SYNC_TIMEOUT);
        fill_random(50);
        set_lane(5, 1'b1, SYNC);
        step();
        nonsync(5, 7 * SYNC_TIMEOUT + SYNC_TIMEOUT - 1);
        flush(3);
        check("hold_locked", locked, 1);
        check("hold_idx", lock_idx, 5);
        check("hold_no_lost", n_lost - base, 0);
        nonsync(5, 1);
        flush(3);
        check("edge_unlocked", locked, 0);
        check("edge_lost_pulses", n_lost - base, 1);

        // Relock request while locked, then lock onto lane 2
        send_syncs(5, 16, 1'b1);
        flush(3);
        check("pre_relock_locked", locked, 1);
        base = n_lost;
        fill_random(50);
        set_lane(5, 1'b1, SYNC);
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        check("relock_unlocked", locked, 0);
        flush(2);
        check("relock_no_lost", n_lost - base, 0);
        send_syncs(2, 16, 1'b1);
        flush(3);
        check("relock_lane2_locked", locked, 1);
        check("relock_lane2_idx", lock_idx, 2);

        // Random traffic with competing sync lanes and sporadic relock pulses
        for (int c = 0; c < 400; c++) begin
            fill_random(75);
            if ($urandom_range(0, 1) == 1) set_lane(7, 1'b1, SYNC);
            if ($urandom_range(0, 1) == 1) set_lane(11, 1'b1, SYNC);
            relock_req = ($urandom_range(0, 63) == 0);
            step();
            relock_req = 1'b0;
        end

        // Asynchronous reset while locked with traffic
        relock();
        send_syncs(0, 16, 1'b0);
        repeat (5) begin
            fill_random(75);
            set_lane(0, 1'b1, ($urandom_range(0, 3) == 0) ? SYNC : rand_word());
            step();
        end
        check("prereset_locked", locked, 1);
        #2 reset_n = 1'b0;
        #1;
        check("areset_locked", locked, 0);
        check("areset_valid_o", valid_o, 0);
        check("areset_lock_lost", lock_lost, 0);
        check("areset_lock_idx", lock_idx, 0);
        check("areset_dataout", dataout, 0);
        check("areset_relock_count", relock_count, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        first_valid = -1;
        for (int c = 1; c <= 40; c++) begin
            fill_random(50);
            set_lane(0, 1'b1, SYNC);
            step();
            if (valid_o && first_valid < 0) first_valid = c;
        end
        check("post_reset_first_valid_cycle", first_valid, LOCK_LEVEL + 2);
        check("post_reset_idx", lock_idx, 0);

        flush(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
